// File: rtl/sync_fifo_serializer_if.sv
// Bundles the write side, shift control, error clear and status/readout
// signals of sync_fifo_serializer. The parameters must match the ones given
// to the FIFO instance that uses this interface.
interface sync_fifo_serializer_if #(
    parameter int unsigned DWIDTH = 136,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned OWIDTH = 16
);
    localparam int unsigned NCHUNK = (DWIDTH + OWIDTH - 1) / OWIDTH;
    localparam int unsigned CIW    = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int unsigned NW     = $clog2(DEPTH) + 1;

    logic              wr_en;
    logic [DWIDTH-1:0] wdata;
    logic              flush;
    logic              shift_en;
    logic              clr_err;
    logic [OWIDTH-1:0] rdata;
    logic              rvalid;
    logic              rlast;
    logic [CIW-1:0]    chunk_idx;
    logic [NW-1:0]     numel;
    logic              empty;
    logic              full;
    logic              almost_full;
    logic              overflow;
    logic              underflow;

    // Producer/consumer side of the FIFO.
    modport master (
        output wr_en, wdata, flush, shift_en, clr_err,
        input  rdata, rvalid, rlast, chunk_idx, numel,
        input  empty, full, almost_full, overflow, underflow
    );

    // FIFO side.
    modport slave (
        input  wr_en, wdata, flush, shift_en, clr_err,
        output rdata, rvalid, rlast, chunk_idx, numel,
        output empty, full, almost_full, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_serializer.sv
// Synchronous FIFO of DWIDTH-bit rows that reads out each head row as
// NCHUNK chunks of OWIDTH bits, one chunk per shift_en. Show-ahead output,
// explicit occupancy counter, sticky overflow/underflow, synchronous flush.
// All outputs decode registered state only.
module sync_fifo_serializer #(
    parameter int unsigned DWIDTH    = 136,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned OWIDTH    = 16,
    parameter int unsigned AFULL_TH  = DEPTH - 2,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    sync_fifo_serializer_if.slave bus
);
    localparam int unsigned NCHUNK = (DWIDTH + OWIDTH - 1) / OWIDTH;
    localparam int unsigned CIW    = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int unsigned AW     = $clog2(DEPTH);
    localparam int unsigned NW     = AW + 1;
    localparam int unsigned PW     = NCHUNK * OWIDTH;

    localparam logic [CIW-1:0] LAST_CHUNK = CIW'(NCHUNK - 1);
    localparam logic [NW-1:0]  DEPTH_N    = NW'(DEPTH);
    localparam logic [NW-1:0]  AFULL_N    = NW'(AFULL_TH);

    logic [DWIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [NW-1:0]  numel_q, numel_d;
    logic [CIW-1:0] chunk_idx_q, chunk_idx_d;
    logic           overflow_q, overflow_d;
    logic           underflow_q, underflow_d;

    logic empty, full, last_chunk;
    logic shift_ok, pop, wr_accept, mem_we;
    logic ovf_set, unf_set;

    logic [PW-1:0]     head_pad;
    logic [OWIDTH-1:0] chunk_arr [NCHUNK];
    logic [CIW-1:0]    sel_idx;

    // Decode occupancy and qualify this cycle's requests.
    always_comb begin
        empty      = (numel_q == '0);
        full       = (numel_q == DEPTH_N);
        last_chunk = (chunk_idx_q == LAST_CHUNK);
        shift_ok   = bus.shift_en && !empty;
        pop        = shift_ok && last_chunk;
        // A pop frees the head slot in the same cycle, so a full FIFO can still take a row.
        wr_accept  = bus.wr_en && (!full || pop);
        mem_we     = wr_accept && !bus.flush;
        ovf_set    = !bus.flush && bus.wr_en && full && !pop;
        unf_set    = !bus.flush && bus.shift_en && empty;
    end

    // Next pointers, occupancy and chunk position; flush overrides everything.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        numel_d     = numel_q;
        chunk_idx_d = chunk_idx_q;
        if (bus.flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            numel_d     = '0;
            chunk_idx_d = '0;
        end else begin
            if (wr_accept) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d    = rd_ptr_q + AW'(1);
                chunk_idx_d = '0;
            end else if (shift_ok) begin
                chunk_idx_d = chunk_idx_q + CIW'(1);
            end
            numel_d = numel_q + NW'(wr_accept) - NW'(pop);
        end
    end

    // Sticky error flags; a new error beats a simultaneous clear.
    always_comb begin
        overflow_d  = ovf_set || (overflow_q && !bus.clr_err);
        underflow_d = unf_set || (underflow_q && !bus.clr_err);
    end

    // Control state registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            numel_q     <= '0;
            chunk_idx_q <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            numel_q     <= numel_d;
            chunk_idx_q <= chunk_idx_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Row storage; contents are don't-care while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= bus.wdata;
        end
    end

    // Zero-extend the head row and split it into chunks in the requested order.
    always_comb begin
        head_pad               = '0;
        head_pad[DWIDTH-1:0]   = mem_q[rd_ptr_q];
        for (int unsigned k = 0; k < NCHUNK; k++) begin
            chunk_arr[k] = head_pad[k*OWIDTH +: OWIDTH];
        end
        sel_idx = MSB_FIRST ? (LAST_CHUNK - chunk_idx_q) : chunk_idx_q;
    end

    // Drive status and the current chunk from registered state.
    always_comb begin
        bus.rdata       = empty ? '0 : chunk_arr[sel_idx];
        bus.rvalid      = !empty;
        bus.rlast       = !empty && last_chunk;
        bus.chunk_idx   = chunk_idx_q;
        bus.numel       = numel_q;
        bus.empty       = empty;
        bus.full        = full;
        bus.almost_full = (numel_q >= AFULL_N);
        bus.overflow    = overflow_q;
        bus.underflow   = underflow_q;
    end
endmodule

// File: tb/tb_sync_fifo_serializer.sv
// Bench for sync_fifo_serializer: two instances (LSB-first and MSB-first
// chunk order) receive identical stimulus and are compared every cycle with
// a queue-based model of the FIFO.
module tb_sync_fifo_serializer;
    localparam int DW = 136;
    localparam int DP = 16;
    localparam int OW = 16;
    localparam int NC = 9;
    localparam int AF = 14;

    logic          clk = 1'b0;
    logic          rst, wr_en, flush, shift_en, clr_err;
    logic [DW-1:0] wdata;

    always #5 clk = ~clk;

    sync_fifo_serializer_if #(.DWIDTH(DW), .DEPTH(DP), .OWIDTH(OW)) bus0 ();
    sync_fifo_serializer_if #(.DWIDTH(DW), .DEPTH(DP), .OWIDTH(OW)) bus1 ();

    assign bus0.wr_en = wr_en;    assign bus1.wr_en = wr_en;
    assign bus0.wdata = wdata;    assign bus1.wdata = wdata;
    assign bus0.flush = flush;    assign bus1.flush = flush;
    assign bus0.shift_en = shift_en; assign bus1.shift_en = shift_en;
    assign bus0.clr_err = clr_err;   assign bus1.clr_err = clr_err;

    sync_fifo_serializer #(.DWIDTH(DW), .DEPTH(DP), .OWIDTH(OW), .AFULL_TH(AF), .MSB_FIRST(1'b0))
        dut0 (.clk(clk), .rst(rst), .bus(bus0));
    sync_fifo_serializer #(.DWIDTH(DW), .DEPTH(DP), .OWIDTH(OW), .AFULL_TH(AF), .MSB_FIRST(1'b1))
        dut1 (.clk(clk), .rst(rst), .bus(bus1));

    // Reference model state
    logic [DW-1:0] mq[$];
    int            mchunk;
    bit            movf, munf;
    int            checks = 0;
    int            errors = 0;

    function automatic logic [OW-1:0] chunk_of(input logic [DW-1:0] row, input int k);
        logic [NC*OW-1:0] w;
        w = '0;
        w[DW-1:0] = row;
        return w[k*OW +: OW];
    endfunction

    function automatic logic [DW-1:0] rand_row();
        logic [159:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return t[DW-1:0];
    endfunction

    task automatic model_reset();
        mq.delete();
        mchunk = 0;
        movf = 1'b0;
        munf = 1'b0;
    endtask

    task automatic model_step();
        int n;
        bit popping, oset, uset;
        n = mq.size();
        oset = 1'b0;
        uset = 1'b0;
        popping = 1'b0;
        if (rst) begin
            model_reset();
            return;
        end
        if (flush) begin
            mq.delete();
            mchunk = 0;
        end else begin
            popping = shift_en && (n > 0) && (mchunk == NC - 1);
            oset = wr_en && (n == DP) && !popping;
            uset = shift_en && (n == 0);
            if (shift_en && n > 0) begin
                if (popping) begin
                    void'(mq.pop_front());
                    mchunk = 0;
                end else begin
                    mchunk++;
                end
            end
            if (wr_en && (n < DP || popping)) mq.push_back(wdata);
        end
        movf = oset || (movf && !clr_err);
        munf = uset || (munf && !clr_err);
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        int n;
        logic [OW-1:0] e0, e1;
        n = mq.size();
        e0 = '0;
        e1 = '0;
        if (n > 0) begin
            e0 = chunk_of(mq[0], mchunk);
            e1 = chunk_of(mq[0], NC - 1 - mchunk);
        end
        chk("empty",       DW'(bus0.empty),       DW'(n == 0));
        chk("full",        DW'(bus0.full),        DW'(n == DP));
        chk("almost_full", DW'(bus0.almost_full), DW'(n >= AF));
        chk("rvalid",      DW'(bus0.rvalid),      DW'(n > 0));
        chk("rlast",       DW'(bus0.rlast),       DW'(n > 0 && mchunk == NC - 1));
        chk("chunk_idx",   DW'(bus0.chunk_idx),   DW'(mchunk));
        chk("numel",       DW'(bus0.numel),       DW'(n));
        chk("overflow",    DW'(bus0.overflow),    DW'(movf));
        chk("underflow",   DW'(bus0.underflow),   DW'(munf));
        chk("rdata_lsb",   DW'(bus0.rdata),       DW'(e0));
        chk("rdata_msb",   DW'(bus1.rdata),       DW'(e1));
        chk("numel_msb",   DW'(bus1.numel),       DW'(n));
        chk("chunk_msb",   DW'(bus1.chunk_idx),   DW'(mchunk));
        chk("rlast_msb",   DW'(bus1.rlast),       DW'(n > 0 && mchunk == NC - 1));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic write_row(input logic [DW-1:0] row);
        wr_en = 1'b1;
        wdata = row;
        cycle();
        wr_en = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] row0, row1, marker, msb_row;
        rst = 1'b1; wr_en = 1'b0; flush = 1'b0; shift_en = 1'b0; clr_err = 1'b0; wdata = '0;
        model_reset();

        // Reset
        cycle();
        cycle();
        rst = 1'b0;
        cycle();
        chk("rst_empty",  DW'(bus0.empty),     DW'(1));
        chk("rst_numel",  DW'(bus0.numel),     DW'(0));
        chk("rst_rdata",  DW'(bus0.rdata),     DW'(0));
        chk("rst_rlast",  DW'(bus0.rlast),     DW'(0));
        chk("rst_ovf",    DW'(bus0.overflow),  DW'(0));
        chk("rst_unf",    DW'(bus0.underflow), DW'(0));

        // Serialize two rows, shifts spaced by 6 idle cycles
        row0 = {{16{8'hA5}}, 8'h00};
        row1 = rand_row();
        row1[7:0] = 8'h01;
        write_row(row0);
        write_row(row1);
        chk("ser_numel2", DW'(bus0.numel), DW'(2));
        for (int s = 1; s <= 18; s++) begin
            if (s == 1)  chk("ser_first_byte0", DW'(bus0.rdata[7:0]), DW'(8'h00));
            if (s == 10) chk("ser_first_byte1", DW'(bus0.rdata[7:0]), DW'(8'h01));
            if (s == 9 || s == 18) begin
                chk("ser_rlast_hi", DW'(bus0.rlast), DW'(1));
                chk("ser_pad_zero", DW'(bus0.rdata[15:8]), DW'(0));
            end else begin
                chk("ser_rlast_lo", DW'(bus0.rlast), DW'(0));
            end
            shift_en = 1'b1;
            cycle();
            shift_en = 1'b0;
            if (s == 9)  chk("ser_numel1", DW'(bus0.numel), DW'(1));
            if (s == 18) begin
                chk("ser_numel0", DW'(bus0.numel), DW'(0));
                chk("ser_empty",  DW'(bus0.empty), DW'(1));
            end
            repeat (6) cycle();
        end

        // Underflow on empty FIFO
        shift_en = 1'b1;
        cycle();
        shift_en = 1'b0;
        chk("unf_set",   DW'(bus0.underflow), DW'(1));
        chk("unf_chunk", DW'(bus0.chunk_idx), DW'(0));
        chk("unf_numel", DW'(bus0.numel),     DW'(0));
        clr_err = 1'b1;
        cycle();
        clr_err = 1'b0;
        chk("unf_clr", DW'(bus0.underflow), DW'(0));

        // Fill to full, then overflow
        for (int i = 1; i <= DP; i++) begin
            write_row(rand_row());
            if (i == 13) chk("fill_af_lo",   DW'(bus0.almost_full), DW'(0));
            if (i == 14) chk("fill_af_hi",   DW'(bus0.almost_full), DW'(1));
            if (i == 15) chk("fill_full_lo", DW'(bus0.full),        DW'(0));
            if (i == 16) chk("fill_full_hi", DW'(bus0.full),        DW'(1));
        end
        write_row(rand_row());
        chk("ovf_set",   DW'(bus0.overflow), DW'(1));
        chk("ovf_numel", DW'(bus0.numel),    DW'(16));
        clr_err = 1'b1;
        cycle();
        clr_err = 1'b0;
        chk("ovf_clr", DW'(bus0.overflow), DW'(0));

        // Full pass-through: write together with the popping shift
        shift_en = 1'b1;
        repeat (8) cycle();
        chk("pt_chunk8", DW'(bus0.chunk_idx), DW'(8));
        marker = rand_row();
        wr_en = 1'b1;
        wdata = marker;
        cycle();
        wr_en = 1'b0;
        chk("pt_numel", DW'(bus0.numel),    DW'(16));
        chk("pt_ovf",   DW'(bus0.overflow), DW'(0));
        repeat (15 * NC) cycle();
        shift_en = 1'b0;
        chk("pt_head_numel", DW'(bus0.numel), DW'(1));
        chk("pt_head_data",  DW'(bus0.rdata), DW'(marker[15:0]));
        shift_en = 1'b1;
        repeat (NC) cycle();
        shift_en = 1'b0;
        chk("pt_drained", DW'(bus0.empty), DW'(1));

        // Flush mid-row with a concurrent write
        write_row(rand_row());
        write_row(rand_row());
        shift_en = 1'b1;
        repeat (4) cycle();
        shift_en = 1'b0;
        chk("fl_chunk4", DW'(bus0.chunk_idx), DW'(4));
        flush = 1'b1;
        wr_en = 1'b1;
        wdata = rand_row();
        cycle();
        flush = 1'b0;
        wr_en = 1'b0;
        chk("fl_empty", DW'(bus0.empty),     DW'(1));
        chk("fl_chunk", DW'(bus0.chunk_idx), DW'(0));
        chk("fl_ovf",   DW'(bus0.overflow),  DW'(0));

        // MSB-first chunk order
        msb_row = {8'h01, 16'h0002, 16'h0003, 16'h0004, 16'h0005,
                   16'h0006, 16'h0007, 16'h0008, 16'h0009};
        write_row(msb_row);
        for (int k = 0; k < NC; k++) begin
            chk("msb_chunk", DW'(bus1.rdata), DW'(k == 0 ? 16'h0001 : 16'(k + 1)));
            shift_en = 1'b1;
            cycle();
            shift_en = 1'b0;
        end
        chk("msb_empty", DW'(bus1.empty), DW'(1));

        // Randomized traffic
        repeat (400) begin
            wr_en    = ($urandom_range(0, 99) < 55);
            shift_en = ($urandom_range(0, 99) < 60);
            flush    = ($urandom_range(0, 99) < 3);
            clr_err  = ($urandom_range(0, 99) < 5);
            wdata    = rand_row();
            cycle();
        end
        wr_en = 1'b0; shift_en = 1'b0; flush = 1'b0; clr_err = 1'b0;
        cycle();

        // Asynchronous reset in the middle of a row
        write_row(rand_row());
        shift_en = 1'b1;
        repeat (3) cycle();
        shift_en = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("arst_chunk", DW'(bus0.chunk_idx), DW'(0));
        chk("arst_empty", DW'(bus0.empty),     DW'(1));
        cycle();
        rst = 1'b0;
        cycle();
        write_row(rand_row());
        chk("post_rst_numel", DW'(bus0.numel), DW'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
